// File: rtl/mult_pkg.sv
// Shared types for the shared-multiplier arbiter: unit select codes, FSM states
// and the product width helper.
package mult_pkg;

  typedef enum logic [1:0] {
    SEL_DSP   = 2'b00,
    SEL_BOOTH = 2'b01,
    SEL_BIT   = 2'b10,
    SEL_SKIP  = 2'b11
  } sel_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } arb_state_t;

  function automatic int prod_width(input int w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/mult_arbiter_rr_picker.sv
// Combinational round-robin selector: first requester after 'last', searched
// cyclically, as one-hot grant plus index.
module rr_picker #(
  parameter int NREQ = 2,
  parameter int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] last,
  output logic [NREQ-1:0] grant,
  output logic [IDXW-1:0] idx,
  output logic            any
);

  logic [IDXW-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int off = 1; off <= NREQ; off++) begin
      cand = IDXW'((int'(last) + off) % NREQ);
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter/sequencer in front of the DSP, Booth and bit-serial
// multipliers, with zero-skip bypass, done watchdog and perf counters.
//
// state    | meaning
// ---------|-----------------------------------------------------------
// ST_IDLE  | waiting for a request; accepts the round-robin winner
// ST_ISSUE | operands on the bus, start pulse to the chosen unit
// ST_WAIT  | operands held, waiting for the chosen unit's done/watchdog
// ST_RESP  | one-cycle response to the owning requester
module mult_arbiter
  import mult_pkg::*;
#(
  parameter int W       = 8,
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*W-1:0]        req_a,
  input  logic [NREQ*W-1:0]        req_b,
  input  logic [NREQ*2-1:0]        req_sel,
  output logic [NREQ-1:0]          resp_valid,
  output logic signed [2*W-1:0]    resp_p,
  output logic                     resp_err,
  output logic signed [W-1:0]      mult_operand_A,
  output logic signed [W-1:0]      mult_operand_B,
  output logic                     start_dsp,
  output logic                     start_booth,
  output logic                     start_bit,
  input  logic                     done_dsp,
  input  logic                     done_booth,
  input  logic                     done_bit,
  input  logic signed [2*W-1:0]    P_dsp,
  input  logic signed [2*W-1:0]    P_booth,
  input  logic signed [2*W-1:0]    P_bit,
  output logic [31:0]              switch_count,
  output logic [31:0]              busy_cycles
);

  localparam int PW   = prod_width(W);
  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WDW  = $clog2(TIMEOUT + 1);

  arb_state_t state, state_nxt;

  logic [IDXW-1:0]      last_grant, id_q, pick_idx;
  logic [NREQ-1:0]      pick_grant;
  logic                 pick_any;
  logic signed [W-1:0]  a_q, b_q;
  sel_t                 sel_q, prev_sel;
  logic                 prev_valid;
  logic [WDW-1:0]       wdog;
  logic signed [PW-1:0] prod_q;
  logic                 err_q;
  logic                 unit_done;
  logic signed [PW-1:0] unit_p;
  logic                 wdog_expired;

  rr_picker #(.NREQ(NREQ), .IDXW(IDXW)) u_picker (
    .req   (req_valid),
    .last  (last_grant),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Only the unit owning the current job is listened to.
  always_comb begin
    unit_done = 1'b0;
    unit_p    = '0;
    case (sel_q)
      SEL_DSP:   begin unit_done = done_dsp;   unit_p = P_dsp;   end
      SEL_BOOTH: begin unit_done = done_booth; unit_p = P_booth; end
      SEL_BIT:   begin unit_done = done_bit;   unit_p = P_bit;   end
      default:   begin unit_done = 1'b0;       unit_p = '0;      end
    endcase
  end

  assign wdog_expired = (wdog == WDW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    req_ready      = '0;
    resp_valid     = '0;
    resp_p         = '0;
    resp_err       = 1'b0;
    mult_operand_A = '0;
    mult_operand_B = '0;
    start_dsp      = 1'b0;
    start_booth    = 1'b0;
    start_bit      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_any && !reset) begin
          req_ready = pick_grant;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        mult_operand_A = a_q;
        mult_operand_B = b_q;
        start_dsp      = (sel_q == SEL_DSP);
        start_booth    = (sel_q == SEL_BOOTH);
        start_bit      = (sel_q == SEL_BIT);
        state_nxt      = (sel_q == SEL_SKIP) ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: begin
        mult_operand_A = a_q;
        mult_operand_B = b_q;
        if (unit_done || wdog_expired) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        resp_valid[id_q] = 1'b1;
        resp_p           = prod_q;
        resp_err         = err_q;
        state_nxt        = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant   <= IDXW'(NREQ - 1);
      id_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      sel_q        <= SEL_DSP;
      prev_sel     <= SEL_DSP;
      prev_valid   <= 1'b0;
      wdog         <= '0;
      prod_q       <= '0;
      err_q        <= 1'b0;
      switch_count <= '0;
      busy_cycles  <= '0;
    end else begin
      if (state != ST_IDLE) busy_cycles <= busy_cycles + 32'd1;
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            id_q  <= pick_idx;
            a_q   <= req_a[pick_idx*W +: W];
            b_q   <= req_b[pick_idx*W +: W];
            sel_q <= sel_t'(req_sel[pick_idx*2 +: 2]);
          end
        end
        ST_ISSUE: begin
          wdog   <= '0;
          err_q  <= 1'b0;
          prod_q <= '0;
          // Zero-skip jobs neither count as a switch nor become the reference unit.
          if (sel_q != SEL_SKIP) begin
            prev_valid <= 1'b1;
            prev_sel   <= sel_q;
            if (prev_valid && (sel_q != prev_sel)) switch_count <= switch_count + 32'd1;
          end
        end
        ST_WAIT: begin
          if (unit_done)         prod_q <= unit_p;
          else if (wdog_expired) err_q  <= 1'b1;
          else                   wdog   <= wdog + WDW'(1);
        end
        ST_RESP: last_grant <= id_q;
        default: ;
      endcase
    end
  end

endmodule
